counter_arb_ctrl: RTL and testbench
===================================

Name: counter_arb_ctrl

Overview:
- Controller for the shared 4-bit up/down count resource.
- Two requesters each submit a job: direction plus step count.
- A round-robin arbiter grants one job at a time; an FSM steps the owned count register once per clock, then signals completion.
- Sits between the requester logic and the count output that is consumed downstream.

Parameters:
- WIDTH, 4, count register width; wraps modulo 2^WIDTH.
- STEPW, 4, width of each requester's step-count field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset: 0 resets, 1 runs.
- req  input  2  per-requester request level; bit i = requester i.
- dir  input  2  per-requester direction; 1 = up, 0 = down. Sampled with req at grant.
- steps0  input  STEPW  requester 0 step count; sampled at grant.
- steps1  input  STEPW  requester 1 step count; sampled at grant.
- gnt  output  2  one-hot, one-cycle grant pulse.
- busy  output  1  high while a job is in RUN or DONE.
- done  output  1  one-cycle completion pulse.
- done_id  output  1  requester index of the completed job; valid while done=1.
- wrap  output  1  one-cycle pulse after a step that wrapped count.
- count  output  WIDTH  current count value.

Behaviour:
- Reset (rst=0, async): state=IDLE; count=0, gnt=0, busy=0, done=0, done_id=0, wrap=0; RR pointer set so requester 0 wins the first tie. A reset mid-job aborts the job with no done pulse.
- All outputs are registered.
- FSM states are IDLE, RUN and DONE.
- IDLE, at clock edge E0:
  - If any req bit is set, select the winner (round-robin, below) and latch the winner's dir and steps into dir_q and rem.
  - Assert gnt[winner] for the cycle after E0 and set busy=1.
  - Next state is RUN if the latched steps are non-zero, otherwise DONE.
  - If steps=0: done is asserted in the same cycle as gnt, and count is unchanged.
- RUN, at each edge E1..EN (N = latched steps):
  - count <= count+1 if dir_q=1, else count-1, modulo 2^WIDTH.
  - rem <= rem-1.
  - At the edge where rem=1, next state is DONE.
- DONE:
  - done=1 and done_id=winner for exactly one cycle, in the cycle after EN.
  - At the next edge the FSM returns to IDLE and busy=0.
  - IDLE samples requests again at the following edge.
  - Job turnaround from E0 to the next possible grant edge is N+2 edges.
- Round-robin arbitration:
  - If only one req bit is set, that requester wins.
  - If both are set, the requester not served last wins.
  - The pointer updates only on a grant.
- Request handling:
  - req is sampled only in IDLE.
  - A requester must hold req until it sees gnt. Dropping req earlier withdraws the request.
  - req, dir and steps changes during RUN or DONE have no effect.
  - A requester still asserting req after its done is treated as a new request.
- wrap is set for one cycle after any RUN edge where count moves 2^WIDTH-1 -> 0 (up) or 0 -> 2^WIDTH-1 (down).
- count holds its value between jobs and is never cleared except by reset.

Decomposition:
- Shared package holds:
  - state encoding constants: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default WIDTH and STEPW;
  - DIR_UP=1 and DIR_DOWN=0.
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter with a registered last-served pointer and an update enable. The top module holds the FSM, count and rem registers.

Test Plan:
- Reset, then req=01, dir[0]=1, steps0=5 -> gnt=01 one cycle after E0; count goes 1..5 on E1..E5; done=1, done_id=0 in the cycle after E5; busy=0 after E6.
- From count=0: req=10, dir[1]=0, steps1=3 -> count goes 15, 14, 13; wrap=1 for one cycle only, after the first step; done_id=1.
- Both req held high with steps 2 each, dir up, from count=0 -> grants go 01 then 10 then 01 (alternating); count goes 2, 4, 6; done_id alternates 0, 1, 0.
- req=01, steps0=0 -> gnt=01 and done=1 in the same cycle; count unchanged; FSM back in IDLE after 2 edges.
- Start an up job with steps=9, then pull rst low after 4 steps -> count=0, busy=0, no done pulse. After rst=1 with both req high, requester 0 is granted first.
- Up job steps=15 from count=3 -> final count 2; wrap pulses once, after the 15->0 step.

Source files
------------

// File: rtl/counter_arb_ctrl_pkg.sv
// Shared definitions for the counter arbitration controller:
// FSM state encoding, default widths and direction values.
package counter_arb_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_STEPW = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_arb_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant from the current
// requests, with a registered last-served pointer updated on enable.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       idx
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        idx = 1'b0;
        case (req)
            2'b01: begin
                gnt = 2'b01;
                idx = 1'b0;
            end
            2'b10: begin
                gnt = 2'b10;
                idx = 1'b1;
            end
            2'b11: begin
                // On a tie, the requester not served last wins
                if (last_q) begin
                    gnt = 2'b01;
                    idx = 1'b0;
                end else begin
                    gnt = 2'b10;
                    idx = 1'b1;
                end
            end
            default: begin
                gnt = 2'b00;
                idx = 1'b0;
            end
        endcase
    end

    // Reset to "requester 1 served last" so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (en && (req != 2'b00)) begin
            last_q <= idx;
        end
    end

endmodule

// File: rtl/counter_arb_ctrl.sv
// Shared up/down count resource: arbitrates two requesters and steps the
// count once per clock for the granted job, then pulses done.
module counter_arb_ctrl
    import counter_arb_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEPW = DEF_STEPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       dir,
    input  logic [STEPW-1:0] steps0,
    input  logic [STEPW-1:0] steps1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             wrap,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [STEPW-1:0] STEP_ONE = STEPW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [STEPW-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             owner_q, owner_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             wrap_q, wrap_d;

    logic [1:0]       arb_gnt;
    logic             arb_idx;
    logic             arb_en;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst),
        .req   (req),
        .en    (arb_en),
        .gnt   (arb_gnt),
        .idx   (arb_idx)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        owner_d   = owner_q;
        gnt_d     = 2'b00;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        wrap_d    = 1'b0;
        arb_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    arb_en  = 1'b1;
                    gnt_d   = arb_gnt;
                    owner_d = arb_idx;
                    dir_d   = dir[arb_idx];
                    rem_d   = arb_idx ? steps1 : steps0;
                    // A zero-step job completes in the grant cycle itself
                    if (rem_d == '0) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        done_id_d = arb_idx;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (dir_q == DIR_UP) begin
                    count_d = count_q + CNT_ONE;
                    wrap_d  = (count_q == '1);
                end else begin
                    count_d = count_q - CNT_ONE;
                    wrap_d  = (count_q == '0);
                end
                rem_d = rem_q - STEP_ONE;
                if (rem_q == STEP_ONE) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            dir_q     <= DIR_DOWN;
            owner_q   <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            wrap_q    <= wrap_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign wrap    = wrap_q;
    assign count   = count_q;

endmodule

// File: tb/tb_counter_arb_ctrl.sv
// Bench for counter_arb_ctrl: directed scenarios plus random requests,
// compared cycle by cycle against a job-level reference model.
module tb_counter_arb_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] dir;
    logic [3:0] steps0;
    logic [3:0] steps1;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       done_id;
    logic       wrap;
    logic [3:0] count;

    counter_arb_ctrl #(.WIDTH(4), .STEPW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .dir     (dir),
        .steps0  (steps0),
        .steps1  (steps1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .wrap    (wrap),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] gnt;
        logic       busy;
        logic       done;
        logic       did;
        logic       wrap;
        int         count;
    } exp_t;

    exp_t q[$];
    int   m_count;
    int   m_last;
    int   n_chk;
    int   n_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expand one granted job into its full expected output timeline
    task automatic build_job();
        exp_t e;
        int   w, n, c, nc;
        bit   up;
        if (req == 2'b11) w = (m_last == 0) ? 1 : 0;
        else              w = req[1] ? 1 : 0;
        m_last = w;
        up = dir[w];
        n  = (w == 1) ? int'(steps1) : int'(steps0);
        c  = m_count;
        e.gnt = (w == 1) ? 2'b10 : 2'b01;
        e.busy = 1'b1; e.done = (n == 0); e.did = w[0]; e.wrap = 1'b0; e.count = c;
        q.push_back(e);
        for (int k = 1; k <= n; k++) begin
            nc = (c + (up ? 1 : 15)) % 16;
            e.gnt = 2'b00; e.busy = 1'b1; e.done = (k == n); e.did = w[0];
            e.wrap = up ? (nc < c) : (nc > c);
            e.count = nc;
            q.push_back(e);
            c = nc;
        end
        // Mandatory idle cycle after DONE, when requests are not yet sampled
        e.gnt = 2'b00; e.busy = 1'b0; e.done = 1'b0; e.did = w[0]; e.wrap = 1'b0; e.count = c;
        q.push_back(e);
        m_count = c;
    endtask

    task automatic step();
        exp_t e;
        if (q.size() == 0 && req != 2'b00) build_job();
        if (q.size() == 0) begin
            e.gnt = 2'b00; e.busy = 1'b0; e.done = 1'b0; e.did = 1'b0; e.wrap = 1'b0;
            e.count = m_count;
        end else begin
            e = q.pop_front();
        end
        @(posedge clk);
        #1;
        chk("gnt",   32'(gnt),   32'(e.gnt));
        chk("busy",  32'(busy),  32'(e.busy));
        chk("done",  32'(done),  32'(e.done));
        chk("wrap",  32'(wrap),  32'(e.wrap));
        chk("count", 32'(count), e.count);
        if (e.done) chk("done_id", 32'(done_id), 32'(e.did));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},   32'(gnt),     0);
        chk({tag, "_busy"},  32'(busy),    0);
        chk({tag, "_done"},  32'(done),    0);
        chk({tag, "_did"},   32'(done_id), 0);
        chk({tag, "_wrap"},  32'(wrap),    0);
        chk({tag, "_count"}, 32'(count),   0);
    endtask

    // Asynchronous reset asserted away from the clock edge
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst");
        q.delete();
        m_count = 0;
        m_last  = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        m_count = 0; m_last = 1;
        rst = 1'b0; req = 2'b00; dir = 2'b00; steps0 = 4'd0; steps1 = 4'd0;
        #2;
        apply_reset();

        // Requester 0, up 5
        req = 2'b01; dir = 2'b01; steps0 = 4'd5;
        step();
        req = 2'b00;
        repeat (8) step();
        chk("s1_final_count", 32'(count), 5);

        // Requester 1, down 3 from zero: wraps on the first step
        apply_reset();
        req = 2'b10; dir = 2'b00; steps1 = 4'd3;
        step();
        req = 2'b00;
        repeat (6) step();
        chk("s2_final_count", 32'(count), 13);

        // Both held, 2 steps each, alternating grants
        apply_reset();
        req = 2'b11; dir = 2'b11; steps0 = 4'd2; steps1 = 4'd2;
        repeat (12) step();
        req = 2'b00;
        repeat (4) step();
        chk("s3_final_count", 32'(count), 6);

        // Zero-step job
        req = 2'b01; steps0 = 4'd0;
        step();
        req = 2'b00;
        repeat (3) step();
        chk("s4_count_held", 32'(count), 6);

        // Reset in the middle of a 9-step job
        apply_reset();
        req = 2'b01; dir = 2'b01; steps0 = 4'd9;
        step();
        req = 2'b00;
        repeat (4) step();
        chk("s5_mid_count", 32'(count), 4);
        apply_reset();
        req = 2'b11; dir = 2'b11; steps0 = 4'd1; steps1 = 4'd1;
        step();
        chk("s5_first_gnt", 32'(gnt), 1);
        req = 2'b00;
        repeat (6) step();

        // Up 15 from 3, wrapping once
        apply_reset();
        req = 2'b01; dir = 2'b01; steps0 = 4'd3;
        step();
        req = 2'b00;
        repeat (5) step();
        req = 2'b01; steps0 = 4'd15;
        step();
        req = 2'b00;
        repeat (18) step();
        chk("s6_final_count", 32'(count), 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            req    = 2'($urandom_range(0, 3));
            dir    = 2'($urandom_range(0, 3));
            steps0 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            steps1 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
